tt_um_halfadder_seq: RTL and testbench

TT_UM_HALFADDER_SEQ -- requirements
Module: tt_um_halfadder_seq

---
 rtl/tt_halfadder_pkg.sv | 23 ++
 rtl/tt_um_halfadder_seq_if.sv | 28 ++
 rtl/half_adder_cell.sv | 12 +
 rtl/tt_um_halfadder_seq.sv | 194 +++++++++++++++++++
 tb/tb_tt_um_halfadder_seq.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/tt_halfadder_pkg.sv
// Shared types and constants for the bit-serial half-adder block:
// FSM state encoding, operand width, phase encodings and the fixed
// bidirectional-pin output enable.
package tt_halfadder_pkg;

  localparam int OP_W  = 4;
  localparam int IDX_W = $clog2(OP_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HA1  = 2'd1,
    ST_HA2  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Reported on uio_out[6]: which of the two half-adder passes is active.
  localparam logic PHASE_HA1 = 1'b0;
  localparam logic PHASE_HA2 = 1'b1;

  // uio[7:2] are outputs, uio[1:0] are the start/abort inputs.
  localparam logic [7:0] UIO_OE_VAL = 8'b1111_1100;

endpackage

// File: rtl/tt_um_halfadder_seq_if.sv
// Pin bundle of the Tiny Tapeout style wrapper. The driver side (master)
// owns the dedicated and bidirectional inputs; the design side (slave)
// owns the outputs. Clock and reset are kept outside the bundle.
interface tt_um_halfadder_seq_if;

  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );

endinterface

// File: rtl/half_adder_cell.sv
// Single half-adder cell; the only arithmetic element in the design.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/tt_um_halfadder_seq.sv
// Bit-serial 4-bit adder built from one time-shared half-adder.
// Each operand bit takes two cycles: HA1 adds A[idx]^B[idx] (propagate /
// generate), HA2 adds the propagate term to the running carry. The result
// register uo_out only updates on entry to DONE.
// Optional build macro: HA_SEQ_SAT_EN -- saturate the 4-bit sum to 4'hF
// when the addition carries out.
module tt_um_halfadder_seq #(
  parameter int OP_W = tt_halfadder_pkg::OP_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  import tt_halfadder_pkg::*;

  state_t state_q, state_d;

  logic              start_q;
  logic              start_evt;
  logic              abort;
  logic [OP_W-1:0]   a_q, b_q, sum_q, sum_nxt;
  logic              carry_q, carry_nxt;
  logic              p_q, g_q;
  logic [IDX_W-1:0]  idx_q;
  logic              done_q;
  logic [OP_W:0]     res_q, res_d;

  logic              capture, latch_pg, write_bit, finish, drop;
  logic              ha_a, ha_b, ha_s, ha_c;
  logic              busy, phase;

  // Power-good and the spare bidirectional inputs have no function here.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, uio_in[7:2]};

  assign start_evt = uio_in[0] & ~start_q;
  assign abort     = uio_in[1];

  // State register and start-level history.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= uio_in[0];
    end
  end

  // Next-state and datapath control strobes.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    latch_pg  = 1'b0;
    write_bit = 1'b0;
    finish    = 1'b0;
    drop      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_evt) begin
          if (abort) begin
            state_d = ST_IDLE;
            drop    = 1'b1;
          end else begin
            state_d = ST_HA1;
            capture = 1'b1;
          end
        end
      end
      ST_HA1: begin
        if (abort) begin
          state_d = ST_IDLE;
          drop    = 1'b1;
        end else begin
          latch_pg = 1'b1;
          state_d  = ST_HA2;
        end
      end
      ST_HA2: begin
        if (abort) begin
          state_d = ST_IDLE;
          drop    = 1'b1;
        end else begin
          write_bit = 1'b1;
          if (idx_q == IDX_W'(OP_W - 1)) begin
            state_d = ST_DONE;
            finish  = 1'b1;
          end else begin
            state_d = ST_HA1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Half-adder input multiplexer, selected purely by FSM state.
  always_comb begin
    ha_a = 1'b0;
    ha_b = 1'b0;
    case (state_q)
      ST_HA1: begin
        ha_a = a_q[idx_q];
        ha_b = b_q[idx_q];
      end
      ST_HA2: begin
        ha_a = p_q;
        ha_b = carry_q;
      end
      default: ;
    endcase
  end

  half_adder_cell u_ha (
    .a (ha_a),
    .b (ha_b),
    .s (ha_s),
    .c (ha_c)
  );

  // Sum vector with the current bit merged in, and the result to publish.
  always_comb begin
    sum_nxt        = sum_q;
    sum_nxt[idx_q] = ha_s;
    carry_nxt      = g_q | ha_c;
`ifdef HA_SEQ_SAT_EN
    res_d = carry_nxt ? {1'b1, {OP_W{1'b1}}} : {carry_nxt, sum_nxt};
`else
    res_d = {carry_nxt, sum_nxt};
`endif
  end

  // Operand, carry, bit-index and result registers.
  // NOTE: these are plain flops, not a memory array, so all of them are
  // cleared by reset, including an operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      p_q     <= 1'b0;
      g_q     <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      if (capture) begin
        a_q     <= ui_in[OP_W-1:0];
        b_q     <= ui_in[2*OP_W-1:OP_W];
        sum_q   <= '0;
        carry_q <= 1'b0;
        idx_q   <= '0;
        done_q  <= 1'b0;
      end
      if (latch_pg) begin
        p_q <= ha_s;
        g_q <= ha_c;
      end
      if (write_bit) begin
        sum_q   <= sum_nxt;
        carry_q <= carry_nxt;
        if (!finish) begin
          idx_q <= idx_q + 1'b1;
        end
      end
      if (finish) begin
        res_q  <= res_d;
        done_q <= 1'b1;
      end
      if (drop) begin
        done_q <= 1'b0;
      end
    end
  end

  assign busy  = (state_q == ST_HA1) || (state_q == ST_HA2);
  assign phase = (state_q == ST_HA2) ? PHASE_HA2 : PHASE_HA1;

  assign uo_out  = {{(7 - OP_W){1'b0}}, res_q};
  assign uio_out = {1'b0, phase, idx_q, done_q, busy, 2'b00};
  assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_halfadder_seq.sv
// Self-checking bench for tt_um_halfadder_seq: directed corner cases plus
// randomized operations, with results checked by a scoreboard monitor.
module tb_tt_um_halfadder_seq;

  logic clk;
  logic rst_n;
  logic ena;

  tt_um_halfadder_seq_if bus ();

  tt_um_halfadder_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (bus.ui_in),
    .uio_in  (bus.uio_in),
    .uo_out  (bus.uo_out),
    .uio_out (bus.uio_out),
    .uio_oe  (bus.uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer addition, optionally clamped.
  function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b);
    int s;
    s = int'(a) + int'(b);
`ifdef HA_SEQ_SAT_EN
    if (s > 15) return 8'h1F;
`endif
    return 8'(s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation: pulse start, count edges to done, watch busy and
  // uo_out stability. Expected result goes to the scoreboard.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input int inj_cycle);
    int n, busy_cnt;
    logic [7:0] uo_before;
    bit stable, seen;
    uo_before = bus.uo_out;
    sb_q.push_back(model(a, b));
    bus.ui_in  = {b, a};
    bus.uio_in = 8'h01;
    step();
    bus.uio_in = 8'h00;
    n = 1; busy_cnt = 0; stable = 1; seen = 0;
    while (!seen && n < 20) begin
      if (bus.uo_out !== uo_before) stable = 0;
      if (bus.uio_out[2]) busy_cnt++;
      if (n == inj_cycle) begin
        bus.ui_in  = 8'hFF;
        bus.uio_in = 8'h01;
      end
      step();
      bus.uio_in = 8'h00;
      n++;
      if (bus.uio_out[3]) seen = 1;
    end
    check("latency_edges", n, 9);
    check("busy_cycles", busy_cnt, 8);
    check("uo_stable_while_busy", stable, 1);
    check("busy_low_in_done", bus.uio_out[2], 0);
  endtask

  // Scoreboard monitor: a rising done means a result is being presented.
  initial begin
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.uio_out[3] === 1'b1 && done_prev !== 1'b1) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: uo_out=0x%0h with no operation pending at %0t",
                   bus.uo_out, $time);
        end else begin
          check("result", bus.uo_out, sb_q.pop_front());
        end
      end
      done_prev = bus.uio_out[3];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] uo_before;
    logic [3:0] ra, rb;

    ena        = 1'b1;
    rst_n      = 1'b0;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    step();
    step();
    check("reset_uo_out", bus.uo_out, 8'h00);
    check("reset_uio_out", bus.uio_out, 8'h00);
    check("reset_uio_oe", bus.uio_oe, 8'hFC);
    rst_n = 1'b1;
    step();

    // 5 + 7
    run_op(4'd5, 4'd7, 0);
    check("a5_b7", bus.uo_out, 8'h0C);
    check("a5_b7_done", bus.uio_out[3], 1);

    // 15 + 1: carry out, saturates when enabled
    run_op(4'd15, 4'd1, 0);
`ifdef HA_SEQ_SAT_EN
    check("a15_b1", bus.uo_out, 8'h1F);
`else
    check("a15_b1", bus.uo_out, 8'h10);
`endif

    // Abort in the middle of 9 + 9
    uo_before  = bus.uo_out;
    bus.ui_in  = 8'h99;
    bus.uio_in = 8'h01;
    step();
    bus.uio_in = 8'h00;
    step();
    step();
    step();
    bus.uio_in = 8'h02;
    step();
    bus.uio_in = 8'h00;
    check("abort_busy", bus.uio_out[2], 0);
    check("abort_done", bus.uio_out[3], 0);
    check("abort_uo_kept", bus.uo_out, uo_before);
    step();
    step();
    check("abort_stays_idle", bus.uio_out[3:2], 2'b00);

    // 3 + 4 with a start pulse and new operands injected at cycle 3
    run_op(4'd3, 4'd4, 3);
    check("ignore_restart", bus.uo_out, 8'h07);

    // Abort together with start from DONE: no capture, no run
    uo_before  = bus.uo_out;
    bus.ui_in  = 8'hEE;
    bus.uio_in = 8'h03;
    step();
    bus.uio_in = 8'h00;
    check("abort_start_busy", bus.uio_out[2], 0);
    check("abort_start_uo", bus.uo_out, uo_before);
    step();
    check("abort_start_still_idle", bus.uio_out[2], 0);

    // Reset at cycle 5 of an operation
    bus.ui_in  = 8'h76;
    bus.uio_in = 8'h01;
    step();
    bus.uio_in = 8'h00;
    for (int i = 0; i < 4; i++) step();
    check("pre_reset_busy", bus.uio_out[2], 1);
    check("pre_reset_uio_oe", bus.uio_oe, 8'hFC);
    rst_n = 1'b0;
    step();
    check("midop_reset_uo_out", bus.uo_out, 8'h00);
    check("midop_reset_uio_out", bus.uio_out, 8'h00);
    check("midop_reset_uio_oe", bus.uio_oe, 8'hFC);
    rst_n = 1'b1;
    step();
    step();
    check("post_reset_idle", bus.uio_out, 8'h00);

    // Start held high for 20 cycles: exactly one operation
    sb_q.push_back(model(4'd1, 4'd2));
    bus.ui_in  = 8'h21;
    bus.uio_in = 8'h01;
    for (int i = 0; i < 20; i++) step();
    check("held_start_uo", bus.uo_out, 8'h03);
    check("held_start_done", bus.uio_out[3], 1);
    bus.uio_in = 8'h00;
    step();

    // Randomized operations against the reference
    for (int i = 0; i < 24; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      run_op(ra, rb, 0);
      step();
    end

    step();
    step();
    check("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
